// File: rtl/btn_debounce.sv
// Push-button conditioner: per-channel 2-flop synchroniser, STABLE/PENDING debounce FSM, rise/fall strobes.
// Optional press-toggled latch per channel enabled by `define BTN_DEBOUNCE_TOGGLE_EN.
module btn_debounce #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic             r_s1;
        logic             r_s2;
        logic             r_level;
        logic             r_rise;
        logic             r_fall;
        logic [CNT_W-1:0] r_cnt;
        state_t           r_state;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_cnt   <= '0;
                r_state <= STABLE;
            end else begin
                r_s1   <= btn_raw[g];
                r_s2   <= r_s1;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                case (r_state)
                    STABLE: begin
                        if (r_s2 != r_level) begin
                            r_state <= PENDING;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    PENDING: begin
                        if (r_s2 == r_level) begin
                            r_state <= STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_MAX) begin
                            // Change accepted: flip level and emit the matching one-cycle strobe.
                            r_level <= ~r_level;
                            r_rise  <= ~r_level;
                            r_fall  <= r_level;
                            r_cnt   <= '0;
                            r_state <= STABLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[g] = r_level;
        assign btn_rise[g]  = r_rise;
        assign btn_fall[g]  = r_fall;

`ifdef BTN_DEBOUNCE_TOGGLE_EN
        logic r_toggle;

        // Flips on the same edge that loads r_rise, so both become visible together.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_toggle <= 1'b0;
            end else if (r_state == PENDING && r_s2 != r_level && r_cnt == CNT_MAX && !r_level) begin
                r_toggle <= ~r_toggle;
            end
        end

        assign btn_toggle[g] = r_toggle;
`else
        assign btn_toggle[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, N_BTN=3; optional toggle checked when the macro is set.
module tb_btn_debounce;

    logic       CLK;
    logic       RST_N;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    logic [2:0] btn_fall;
    logic [2:0] btn_toggle;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_tog = 3'b000;

    btn_debounce #(.N_BTN(3), .DEBOUNCE_CYCLES(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_toggle(btn_toggle)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [2:0] lvl, input logic [2:0] rise,
                         input logic [2:0] fall);
`ifdef BTN_DEBOUNCE_TOGGLE_EN
        exp_tog = exp_tog ^ rise;
`endif
        n_checks++;
        assert (btn_level === lvl) else begin
            n_errors++;
            $error("FAIL %s level: got %b want %b", tag, btn_level, lvl);
        end
        n_checks++;
        assert (btn_rise === rise) else begin
            n_errors++;
            $error("FAIL %s rise: got %b want %b", tag, btn_rise, rise);
        end
        n_checks++;
        assert (btn_fall === fall) else begin
            n_errors++;
            $error("FAIL %s fall: got %b want %b", tag, btn_fall, fall);
        end
        n_checks++;
        assert (btn_toggle === exp_tog) else begin
            n_errors++;
            $error("FAIL %s toggle: got %b want %b", tag, btn_toggle, exp_tog);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic cyc(input string tag, input logic [2:0] lvl, input logic [2:0] rise,
                       input logic [2:0] fall);
        @(posedge CLK);
        #1;
        check(tag, lvl, rise, fall);
    endtask

    // Apply new_raw before edge 0; level must flip exactly after edge 5, strobe for that cycle only.
    task automatic accept(input string tag, input logic [2:0] new_raw, input logic [2:0] prev,
                          input logic [2:0] nxt);
        btn_raw = new_raw;
        for (int i = 0; i < 5; i++) cyc({tag, "_wait"}, prev, 3'b000, 3'b000);
        cyc({tag, "_flip"}, nxt, nxt & ~prev, prev & ~nxt);
        cyc({tag, "_after"}, nxt, 3'b000, 3'b000);
    endtask

    initial begin
        RST_N   = 1'b0;
        btn_raw = 3'b000;
        repeat (2) @(posedge CLK);
        #1;
        check("reset", 3'b000, 3'b000, 3'b000);
        RST_N = 1'b1;

        // Channel 0 press accepted; channels 1 and 2 stay quiet.
        accept("press0", 3'b001, 3'b000, 3'b001);

        // Two-cycle glitch on channel 1 must not leak out.
        btn_raw = 3'b011;
        cyc("glitch1_a", 3'b001, 3'b000, 3'b000);
        cyc("glitch1_b", 3'b001, 3'b000, 3'b000);
        btn_raw = 3'b001;
        for (int i = 0; i < 8; i++) cyc("glitch1_q", 3'b001, 3'b000, 3'b000);

        // Bounce 1,0,1,1,... on channel 2: last 0->1 sample at edge 2, level after edge 7.
        btn_raw = 3'b101;
        cyc("bounce2_e0", 3'b001, 3'b000, 3'b000);
        btn_raw = 3'b001;
        cyc("bounce2_e1", 3'b001, 3'b000, 3'b000);
        btn_raw = 3'b101;
        for (int i = 2; i < 7; i++) cyc("bounce2_wait", 3'b001, 3'b000, 3'b000);
        cyc("bounce2_flip", 3'b101, 3'b100, 3'b000);
        for (int i = 0; i < 3; i++) cyc("bounce2_after", 3'b101, 3'b000, 3'b000);

        // Channel 0 release.
        accept("release0", 3'b100, 3'b101, 3'b100);

        // Reset while channel 0 is PENDING with cnt=2 (after edge 3).
        btn_raw = 3'b101;
        for (int i = 0; i < 4; i++) cyc("pend0", 3'b100, 3'b000, 3'b000);
        RST_N = 1'b0;
        #1;
        exp_tog = 3'b000;
        check("async_reset", 3'b000, 3'b000, 3'b000);
        @(posedge CLK);
        #1;
        check("in_reset", 3'b000, 3'b000, 3'b000);
        RST_N = 1'b1;
        // Both held channels re-accepted through the full latency.
        accept("reaccept", 3'b101, 3'b000, 3'b101);

        // Two more presses on channel 0 (toggle sequence 1,0,1 across three presses).
        accept("rel0_b", 3'b100, 3'b101, 3'b100);
        accept("press0_b", 3'b101, 3'b100, 3'b101);
        accept("rel0_c", 3'b100, 3'b101, 3'b100);
        accept("press0_c", 3'b101, 3'b100, 3'b101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-conditioning stage between the board push-buttons (BTN1..BTN3) and the gate-test logic and LED drivers downstream.
- Synchronises each raw button into the CLK domain and filters contact bounce with a per-channel counter FSM.
- Produces a clean level, one-cycle rise/fall strobes, and optionally a press-toggled latch per channel.

Parameters:
- N_BTN, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 12000, consecutive stable CLK cycles required to accept a change (1 ms at 12 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width (derived localparam, not overridable).

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RST_N  input  1  asynchronous, active-low reset; deassertion synchronised externally.
- btn_raw  input  N_BTN  raw active-high button pins, asynchronous to CLK.
- btn_level  output  N_BTN  debounced level per channel.
- btn_rise  output  N_BTN  one-cycle strobe on accepted 0->1.
- btn_fall  output  N_BTN  one-cycle strobe on accepted 1->0.
- btn_toggle  output  N_BTN  toggles on each accepted rise (feature-gated, see below).

Behaviour:
- Reset (RST_N low, asynchronous): sync flops, counters, btn_level, btn_rise, btn_fall and btn_toggle all 0; every FSM to STABLE.
- Reset asserted mid-count discards the pending change. After release, a held button is re-accepted through the full latency path.
- Synchroniser: 2 flops per channel (s1 <= btn_raw, s2 <= s1). The FSM uses s2 only. Raw is never used combinationally.
- Per-channel FSM, states STABLE and PENDING:
  - STABLE, s2 == level: stay; cnt = 0.
  - STABLE, s2 != level: go to PENDING; cnt <= 1.
  - PENDING, s2 == level (bounce back): return to STABLE; cnt <= 0; no strobe.
  - PENDING, s2 != level, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - PENDING, s2 != level, cnt == DEBOUNCE_CYCLES-1: level <= ~level; cnt <= 0; go to STABLE; assert the matching strobe.
- Latency: raw stable from sampling edge k gives s2 valid after edge k+1. level changes after edge k+1+DEBOUNCE_CYCLES. Example: DEBOUNCE_CYCLES=4 gives edge k+5.
- Strobes:
  - Registered; high for exactly the one cycle following the level-flip edge.
  - rise and fall are never high together.
  - No strobe ever without a level change.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output activity.
- Channels are fully independent; simultaneous changes on several channels are each accepted on their own schedule.
- The counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
- All outputs are registered; no combinational path from btn_raw to any output.

Optional Feature:
- Macro: BTN_DEBOUNCE_TOGGLE_EN
- Defined:
  - btn_toggle[i] flips on the same edge that btn_rise[i] is asserted, i.e. visible together with the rise strobe.
  - Reset value 0.
  - Unaffected by fall events.
- Undefined:
  - No toggle flops are synthesised.
  - btn_toggle is tied to constant 0; the port remains for a stable interface.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=3):
- Reset then btn_raw=3'b001 held from edge 0 -> btn_level[0]=1 after edge 5; btn_rise[0]=1 in that cycle only; channels 1 and 2 stay 0.
- btn_raw[1] pulses high for 2 cycles, then low -> btn_level, btn_rise and btn_fall remain 0 throughout.
- Bounce pattern 1,0,1,1,1,1 on btn_raw[2] -> exactly one btn_rise[2]; btn_level[2]=1 five edges after the last 0->1 sampling.
- Stable-high channel 0 then btn_raw[0]=0 held -> btn_fall[0] one cycle and btn_level[0]=0 five edges later; btn_rise[0] never asserts.
- RST_N pulsed low during PENDING (cnt=2) with button held -> all outputs 0 immediately; after release, level rises at the full latency with one rise strobe.
- With BTN_DEBOUNCE_TOGGLE_EN: three accepted presses on channel 0 -> btn_toggle[0] sequence 1,0,1, changing with each rise strobe. Without the macro: btn_toggle stays 3'b000.
